color_dominance_classifier: RTL

- Parametrised successor to the camera-path dominant-colour detector.
- Walks the frame buffer one address per clock and reads packed RGB pixels of configurable field widths.
- Accumulates full channel intensities normalised to 8 bits, not just the channel MSBs.
- Reports the dominant colour using a configurable dominance margin, with busy/done handshake, abort, and continuous back-to-back frame mode.

---
 rtl/color_dominance_classifier.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/color_dominance_classifier.sv
// Dominant-colour classifier: scans one frame from the frame buffer, sums the
// normalised R/G/B intensities and reports which channel dominates by MARGIN.
module color_dominance_classifier #(
  parameter int AW     = 15,
  parameter int NPIX   = 25344,
  parameter int RW     = 3,
  parameter int GW     = 3,
  parameter int BW     = 2,
  parameter int DW     = RW + GW + BW,
  parameter int RD_LAT = 1,
  parameter int SW     = 24,
  parameter int MARGIN = 0
) (
  input  logic          P,
  input  logic          rst,
  input  logic          read,
  input  logic [DW-1:0] data,
  output logic [AW-1:0] addr,
  output logic          busy,
  output logic          done,
  output logic          RED_out,
  output logic          GREEN_out,
  output logic          BLUE_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DRAIN  = 2'd2,
    S_DECIDE = 2'd3
  } state_t;

  localparam int            DCW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [DCW-1:0] LAST_DRAIN = DCW'(RD_LAT - 1);
  localparam logic [SW:0]   MARGIN_W  = (SW + 1)'(MARGIN);

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_addr;
  logic [DCW-1:0]  r_drain_cnt;
  logic [RD_LAT-1:0] r_vld;
  logic [SW-1:0]   r_sum_r;
  logic [SW-1:0]   r_sum_g;
  logic [SW-1:0]   r_sum_b;
  logic            r_done;
  logic            r_red;
  logic            r_green;
  logic            r_blue;

  logic            w_abort;
  logic            w_issue;
  logic            w_start;
  logic [7:0]      w_r8;
  logic [7:0]      w_g8;
  logic [7:0]      w_b8;
  logic [SW:0]     w_sr;
  logic [SW:0]     w_sg;
  logic [SW:0]     w_sb;
  logic            w_r_win;
  logic            w_g_win;
  logic            w_b_win;

  // Dropping read while a frame is being fetched abandons it without a result.
  assign w_abort = ((r_state == S_READ) || (r_state == S_DRAIN)) && !read;
  // A pixel request is genuinely issued only on a READ cycle that continues.
  assign w_issue = (r_state == S_READ) && read;
  assign w_start = (r_state == S_IDLE) && read;

  // Left-align each colour field to 8 bits so channels of different width
  // are compared on the same intensity scale.
  assign w_r8 = 8'(data[DW-1 -: RW]) << (8 - RW);
  assign w_g8 = 8'(data[BW+GW-1 -: GW]) << (8 - GW);
  assign w_b8 = 8'(data[BW-1:0]) << (8 - BW);

  // One extra bit so adding the margin can never wrap.
  assign w_sr    = {1'b0, r_sum_r};
  assign w_sg    = {1'b0, r_sum_g};
  assign w_sb    = {1'b0, r_sum_b};
  assign w_r_win = (w_sr > w_sg + MARGIN_W) && (w_sr > w_sb + MARGIN_W);
  assign w_g_win = (w_sg > w_sr + MARGIN_W) && (w_sg > w_sb + MARGIN_W);
  assign w_b_win = (w_sb > w_sr + MARGIN_W) && (w_sb > w_sg + MARGIN_W);

  // State register.
  always_ff @(posedge P or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> READ (NPIX cycles) -> DRAIN (RD_LAT) -> DECIDE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (read) w_state_next = S_READ;
      S_READ:   if (!read) w_state_next = S_IDLE;
                else if (r_addr == LAST_ADDR) w_state_next = S_DRAIN;
      S_DRAIN:  if (!read) w_state_next = S_IDLE;
                else if (r_drain_cnt == LAST_DRAIN) w_state_next = S_DECIDE;
      S_DECIDE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Address walks 0..NPIX-1 during READ, holds at the last pixel, and is
  // parked at 0 whenever the controller heads back to IDLE.
  always_ff @(posedge P or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE:   r_addr <= '0;
        S_READ:   if (!read) r_addr <= '0;
                  else if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
        S_DRAIN:  if (!read) r_addr <= '0;
        S_DECIDE: r_addr <= '0;
        default:  r_addr <= '0;
      endcase
    end
  end

  // Counts DRAIN cycles so the last in-flight pixel lands before DECIDE.
  always_ff @(posedge P or negedge rst) begin
    if (!rst)                    r_drain_cnt <= '0;
    else if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
    else                         r_drain_cnt <= '0;
  end

  // Read-valid pipeline: a bit enters when an address is issued and reaches
  // the top exactly when the matching pixel is on the data bus.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        // First stage tracks issued addresses.
        always_ff @(posedge P or negedge rst) begin
          if (!rst)         r_vld[0] <= 1'b0;
          else if (w_abort) r_vld[0] <= 1'b0;
          else              r_vld[0] <= w_issue;
        end
      end else begin : g_tail
        // Later stages delay the valid flag by one clock each.
        always_ff @(posedge P or negedge rst) begin
          if (!rst)         r_vld[gi] <= 1'b0;
          else if (w_abort) r_vld[gi] <= 1'b0;
          else              r_vld[gi] <= r_vld[gi-1];
        end
      end
    end
  endgenerate

  // Channel accumulators: cleared at frame start, summed on each valid pixel.
  always_ff @(posedge P or negedge rst) begin
    if (!rst) begin
      r_sum_r <= '0;
      r_sum_g <= '0;
      r_sum_b <= '0;
    end else if (w_start) begin
      r_sum_r <= '0;
      r_sum_g <= '0;
      r_sum_b <= '0;
    end else if (r_vld[RD_LAT-1]) begin
      r_sum_r <= r_sum_r + SW'(w_r8);
      r_sum_g <= r_sum_g + SW'(w_g8);
      r_sum_b <= r_sum_b + SW'(w_b8);
    end
  end

  // Result registers: updated only in DECIDE, together with the done pulse.
  always_ff @(posedge P or negedge rst) begin
    if (!rst) begin
      r_done  <= 1'b0;
      r_red   <= 1'b0;
      r_green <= 1'b0;
      r_blue  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_DECIDE) begin
        r_done  <= 1'b1;
        r_red   <= w_r_win;
        r_green <= w_g_win;
        r_blue  <= w_b_win;
      end
    end
  end

  assign addr      = r_addr;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign RED_out   = r_red;
  assign GREEN_out = r_green;
  assign BLUE_out  = r_blue;

endmodule
